// File: rtl/vga_frame_sequencer.sv
// ============================================================================
// Module      : vga_frame_sequencer
// Description : Redraws a full frame from one of N_SCREENS ROMs after each
//               V_SYNC falling edge; screen changes commit at frame start.
//               Optional macro CURSOR_OVERLAY_EN adds a mouse cursor overlay.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module vga_frame_sequencer #(
    parameter int H_RES     = 320,
    parameter int V_RES     = 240,
    parameter int X_W       = 9,
    parameter int Y_W       = 8,
    parameter int COLOR_W   = 3,
    parameter int N_SCREENS = 4,
    parameter int ADDR_W    = 17,
    parameter int S_W       = 2
`ifdef CURSOR_OVERLAY_EN
    ,
    parameter int                 CURSOR_SIZE  = 4,
    parameter logic [COLOR_W-1:0] CURSOR_COLOR = 3'b111
`endif
) (
    input  logic                           clk,
    input  logic                           iReset,
    input  logic                           V_SYNC,
    input  logic                           keyPress,
    output logic [ADDR_W-1:0]              oRomAddr,
    input  logic [N_SCREENS*COLOR_W-1:0]   iRomData,
`ifdef CURSOR_OVERLAY_EN
    input  logic [X_W-1:0]                 iMouseX,
    input  logic [Y_W-1:0]                 iMouseY,
`endif
    output logic [X_W-1:0]                 x,
    output logic [Y_W-1:0]                 y,
    output logic [COLOR_W-1:0]             color,
    output logic                           writeEn,
    output logic [S_W-1:0]                 oScreen,
    output logic                           oFrameDone,
    output logic                           oOverrun
);

    localparam logic [0:0]         c_IDLE        = 1'b0;
    localparam logic [0:0]         c_DRAW        = 1'b1;
    localparam logic [X_W-1:0]     c_X_LAST      = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0]     c_Y_LAST      = Y_W'(V_RES - 1);
    localparam logic [S_W-1:0]     c_SCREEN_LAST = S_W'(N_SCREENS - 1);

    logic [0:0]          r_state;
    logic [0:0]          w_nextState;
    logic                r_vsPrev;
    logic                r_keyPrev;
    logic                r_pending;
    logic [X_W-1:0]      r_scanX;
    logic [Y_W-1:0]      r_scanY;
    logic [ADDR_W-1:0]   r_romAddr;
    logic [S_W-1:0]      r_screen;
    logic                r_wrEn;
    logic [X_W-1:0]      r_x;
    logic [Y_W-1:0]      r_y;
    logic                r_frameDone;

    logic                w_syncEdge;
    logic                w_keyEdge;
    logic                w_lastIssue;
    logic                w_start;
    logic                w_issue;
    logic                w_overrun;
    logic [COLOR_W-1:0]  w_romPixel;

    assign w_syncEdge  = r_vsPrev & ~V_SYNC;
    assign w_keyEdge   = keyPress & ~r_keyPrev;
    assign w_lastIssue = (r_scanX == c_X_LAST) && (r_scanY == c_Y_LAST);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (iReset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_IDLE:  if (w_syncEdge)  w_nextState = c_DRAW;
            c_DRAW:  if (w_lastIssue) w_nextState = c_IDLE;
            default: w_nextState = c_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_start   = 1'b0;
        w_issue   = 1'b0;
        w_overrun = 1'b0;
        case (r_state)
            c_IDLE: w_start = w_syncEdge;
            c_DRAW: begin
                w_issue   = 1'b1;
                // A sync edge mid-frame is reported but never restarts the scan.
                w_overrun = w_syncEdge & ~iReset;
            end
            default: ;
        endcase
    end

    // Stage 0: raster scan; the address tracks y*H_RES+x by incrementing.
    always_ff @(posedge clk) begin
        if (iReset || w_start) begin
            r_scanX   <= '0;
            r_scanY   <= '0;
            r_romAddr <= '0;
        end else if (w_issue) begin
            if (r_scanX == c_X_LAST) begin
                r_scanX <= '0;
                r_scanY <= r_scanY + Y_W'(1);
            end else begin
                r_scanX <= r_scanX + X_W'(1);
            end
            r_romAddr <= r_romAddr + ADDR_W'(1);
        end
    end

    // Edge detectors, pending request and screen selection.
    always_ff @(posedge clk) begin
        if (iReset) begin
            r_vsPrev  <= 1'b1;
            r_keyPrev <= 1'b1;
            r_pending <= 1'b0;
            r_screen  <= '0;
        end else begin
            r_vsPrev  <= V_SYNC;
            r_keyPrev <= keyPress;
            if (w_start) begin
                if (r_pending) begin
                    r_screen <= (r_screen == c_SCREEN_LAST) ? '0 : r_screen + S_W'(1);
                end
                // A press coinciding with frame start belongs to the next frame.
                r_pending <= w_keyEdge;
            end else if (w_keyEdge) begin
                r_pending <= 1'b1;
            end
        end
    end

    // Stage 1: coordinates delayed to line up with the ROM's one-cycle latency.
    always_ff @(posedge clk) begin
        if (iReset) begin
            r_wrEn      <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_frameDone <= 1'b0;
        end else begin
            r_wrEn      <= w_issue;
            r_x         <= r_scanX;
            r_y         <= r_scanY;
            r_frameDone <= r_wrEn && (r_x == c_X_LAST) && (r_y == c_Y_LAST);
        end
    end

    assign w_romPixel = iRomData[r_screen*COLOR_W +: COLOR_W];

`ifdef CURSOR_OVERLAY_EN
    logic [X_W-1:0] r_mouseX;
    logic [Y_W-1:0] r_mouseY;
    logic [X_W:0]   w_cursorXEnd;
    logic [Y_W:0]   w_cursorYEnd;
    logic           w_inCursor;

    always_ff @(posedge clk) begin
        if (iReset) begin
            r_mouseX <= '0;
            r_mouseY <= '0;
        end else if (w_start) begin
            r_mouseX <= iMouseX;
            r_mouseY <= iMouseY;
        end
    end

    // Extra bit keeps the end bound from wrapping near the screen edge.
    assign w_cursorXEnd = {1'b0, r_mouseX} + (X_W+1)'(CURSOR_SIZE);
    assign w_cursorYEnd = {1'b0, r_mouseY} + (Y_W+1)'(CURSOR_SIZE);
    assign w_inCursor   = (r_x >= r_mouseX) && ({1'b0, r_x} < w_cursorXEnd) &&
                          (r_y >= r_mouseY) && ({1'b0, r_y} < w_cursorYEnd);
    assign color        = !r_wrEn ? '0 : (w_inCursor ? CURSOR_COLOR : w_romPixel);
`else
    assign color        = r_wrEn ? w_romPixel : '0;
`endif

    assign oRomAddr   = r_romAddr;
    assign x          = r_x;
    assign y          = r_y;
    assign writeEn    = r_wrEn;
    assign oScreen    = r_screen;
    assign oFrameDone = r_frameDone;
    assign oOverrun   = w_overrun;

endmodule

`default_nettype wire
